memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS pipeline, downstream of the execute stage.
- Holds the EX/MEM pipeline register and runs the load/store handshake with data memory, which may insert wait states.
- Owns the MEM/WB register and feeds the MEM-stage forwarding values back to execute.
- Stalls the front of the pipeline while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without ack before the timeout error is raised (range 1..65535).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low
memToRegInput  in  1  EX result: write-back selects memory data
regWriteInput  in  1  EX result: register write enable
memWriteInput  in  1  EX result: store
memReadInput  in  1  EX result: load
aluResultInput  in  32  EX result: ALU result / effective address
memWriteDataInput  in  32  EX result: store data (forwarded rt)
regWriteRegisterInput  in  5  EX result: destination register
memAckInput  in  1  data memory: access complete this cycle
memReadDataInput  in  32  data memory: load data, valid when memAckInput=1
memReqOutput  out  1  data memory: request
memWeOutput  out  1  data memory: 1=write, 0=read
memAddressOutput  out  32  data memory: word address (byte address, [1:0]=0)
memWriteDataOutput  out  32  data memory: store data
aluResultMemOutput  out  32  forwarding: EX/MEM ALU result
regWriteMemOutput  out  1  forwarding: EX/MEM register write enable
regWriteRegisterMemOutput  out  5  forwarding: EX/MEM destination register
memToRegOutput  out  1  MEM/WB: select memory data
regWriteOutput  out  1  MEM/WB: register write enable
readDataOutput  out  32  MEM/WB: load data
aluResultOutput  out  32  MEM/WB: ALU result
regWriteRegisterOutput  out  5  MEM/WB: destination register
stallOutput  out  1  hold PC, IF/ID, ID/EX and EX/MEM
errorOutput  out  1  sticky fault
errorCodeOutput  out  2  01=misaligned, 10=timeout, 00=none

Behaviour:
- Reset, asynchronous, active-low:
  - all outputs, EX/MEM and MEM/WB registers and the WAIT counter go to 0.
  - state goes to IDLE.
- Pipeline advance:
  - When stallOutput=0, EX/MEM captures all *Input at the clock edge and MEM/WB captures the EX/MEM contents.
  - For non-memory instructions the latency is 1 cycle per register.
- Stall cycles:
  - EX/MEM holds its contents.
  - MEM/WB loads a bubble: regWriteOutput=0, memToRegOutput=0, other fields hold.
- Forwarding outputs: combinational copies of the EX/MEM fields. regWriteMemOutput is forced to 0 when regWriteRegisterMemOutput=0.
- Memory op: EX/MEM has memRead or memWrite set. If both are set, the access is a write.
- FSM states are IDLE, WAIT and ERROR.
- IDLE:
  - memReqOutput=0.
  - At an advancing edge that captures a memory op with aluResultInput[1:0]=0, go to WAIT.
  - If the captured op is misaligned, go to ERROR with code 01.
- WAIT:
  - memReqOutput=1; memWeOutput, memAddressOutput and memWriteDataOutput are driven from EX/MEM.
  - stallOutput = ~memAckInput (combinational). An ack in the first WAIT cycle therefore costs zero stall cycles.
  - On ack: readDataOutput captures memReadDataInput (loads only; stores leave it unchanged) and the WAIT counter clears.
  - Next state on ack: WAIT again if the newly captured EX/MEM instruction is an aligned memory op; ERROR (01) if it is misaligned; IDLE otherwise.
  - Without ack: the counter increments. When it reaches TIMEOUT_CYCLES, go to ERROR with code 10.
- ERROR:
  - memReqOutput=0, stallOutput=1, errorOutput=1, errorCodeOutput holds the fault code.
  - Leaves ERROR only on reset.
- memAckInput outside WAIT is ignored.
- Address, write-enable and data outputs are stable for the whole WAIT period.
- Reset mid-WAIT:
  - request drops immediately (asynchronous).
  - the pending access is abandoned and is not re-issued.

Test Plan:
- ALU op: regWriteInput=1, aluResultInput=0x0000_002A, dest 5, no mem op → aluResultMemOutput=0x2A next cycle, aluResultOutput=0x2A one cycle later, stallOutput never 1.
- Load with 0 wait: memReadInput=1, address 0x100, ack in first WAIT cycle, data 0xDEADBEEF → memReq for exactly 1 cycle, no stall, readDataOutput=0xDEADBEEF, memToRegOutput=1.
- Store with 3 wait states: memWriteInput=1, address 0x200, data 0x1234 → memReq=1 and memWe=1 for 4 cycles, stallOutput=1 for 3, MEM/WB bubble with regWriteOutput=0 during the stall, EX/MEM unchanged.
- Back-to-back loads, each acked immediately → two consecutive request cycles at addresses 0x10 and 0x14, FSM stays in WAIT, no stall.
- Misaligned: load at 0x102 → no memReq, errorOutput=1, errorCodeOutput=01, stallOutput=1 until reset. TIMEOUT_CYCLES=4 with no ack → errorCodeOutput=10 after 4 WAIT cycles, memReq drops.
- reset=0 asserted mid-WAIT → memReqOutput and stallOutput go to 0 without waiting for a clock edge, all MEM/WB outputs 0, FSM in IDLE after release.

Source files
------------

// File: rtl/memory_access_if.sv
// ----------------------------------------------------------------------------
// memory_access_if
// Load/store handshake between the MEM pipeline stage and data memory.
//
// Signals:
//   memReqOutput        stage -> memory  access request (held until ack)
//   memWeOutput         stage -> memory  1 = write, 0 = read
//   memAddressOutput    stage -> memory  word-aligned byte address
//   memWriteDataOutput  stage -> memory  store data
//   memAckInput         memory -> stage  access completes this cycle
//   memReadDataInput    memory -> stage  load data, valid with memAckInput
//
// Modports:
//   master  the MEM stage (issues requests)
//   slave   the data memory (answers requests)
// ----------------------------------------------------------------------------
interface memory_access_if;
  logic        memReqOutput;
  logic        memWeOutput;
  logic [31:0] memAddressOutput;
  logic [31:0] memWriteDataOutput;
  logic        memAckInput;
  logic [31:0] memReadDataInput;

  modport master (
    output memReqOutput,
    output memWeOutput,
    output memAddressOutput,
    output memWriteDataOutput,
    input  memAckInput,
    input  memReadDataInput
  );

  modport slave (
    input  memReqOutput,
    input  memWeOutput,
    input  memAddressOutput,
    input  memWriteDataOutput,
    output memAckInput,
    output memReadDataInput
  );
endinterface

// File: rtl/memory_access.sv
// ----------------------------------------------------------------------------
// memory_access
// MEM stage of the 5-stage MIPS pipeline. Holds the EX/MEM register, runs the
// load/store handshake with a data memory that may insert wait states, owns
// the MEM/WB register and returns the EX/MEM values to execute for forwarding.
// While an access is outstanding (or after a fault) the front of the pipeline
// is stalled.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles without ack before the timeout fault (1..65535)
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   *Input (EX result)         memToReg, regWrite, memWrite, memRead,
//                              aluResult/address, store data, destination reg
//   mem                        data memory handshake (master side)
//   *MemOutput                 forwarding copies of the EX/MEM fields
//   memToRegOutput .. regWriteRegisterOutput
//                              MEM/WB register contents
//   stallOutput                hold PC, IF/ID, ID/EX and EX/MEM
//   errorOutput, errorCodeOutput
//                              sticky fault flag, 01 misaligned / 10 timeout
// ----------------------------------------------------------------------------
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  memToRegInput,
  input  logic                  regWriteInput,
  input  logic                  memWriteInput,
  input  logic                  memReadInput,
  input  logic [31:0]           aluResultInput,
  input  logic [31:0]           memWriteDataInput,
  input  logic [4:0]            regWriteRegisterInput,

  memory_access_if.master       mem,

  output logic [31:0]           aluResultMemOutput,
  output logic                  regWriteMemOutput,
  output logic [4:0]            regWriteRegisterMemOutput,

  output logic                  memToRegOutput,
  output logic                  regWriteOutput,
  output logic [31:0]           readDataOutput,
  output logic [31:0]           aluResultOutput,
  output logic [4:0]            regWriteRegisterOutput,

  output logic                  stallOutput,
  output logic                  errorOutput,
  output logic [1:0]            errorCodeOutput
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [1:0]  CODE_MISALIGNED = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT    = 2'b10;
  localparam logic [15:0] WAIT_LAST       = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] wait_count_q, wait_count_d;

  // EX/MEM register
  logic        ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_mem_write_q, ex_mem_write_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic [31:0] ex_alu_result_q, ex_alu_result_d;
  logic [31:0] ex_write_data_q, ex_write_data_d;
  logic [4:0]  ex_dest_q, ex_dest_d;

  // MEM/WB register
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_dest_q, wb_dest_d;

  logic        in_wait;
  logic        stall;
  logic        ex_is_load;
  logic        in_mem_op;
  logic        in_misaligned;
  state_t      capture_state;
  logic [1:0]  capture_code;

  // Stall is combinational on ack so a first-cycle ack costs no bubble.
  // A store wins when both read and write are flagged, so only a pure read
  // is treated as a load.
  always_comb begin
    in_wait       = (state_q == WAIT);
    stall         = (state_q == ERROR) || (in_wait && !mem.memAckInput);
    ex_is_load    = ex_mem_read_q && !ex_mem_write_q;
    in_mem_op     = memReadInput || memWriteInput;
    in_misaligned = (aluResultInput[1:0] != 2'b00);

    // Where the FSM goes when an advancing edge captures the current EX result
    capture_state = IDLE;
    capture_code  = err_code_q;
    if (in_mem_op) begin
      if (in_misaligned) begin
        capture_state = ERROR;
        capture_code  = CODE_MISALIGNED;
      end else begin
        capture_state = WAIT;
      end
    end
  end

  // Next-state logic for the pipeline registers, the wait counter and the FSM
  always_comb begin
    state_d         = state_q;
    err_code_d      = err_code_q;
    wait_count_d    = wait_count_q;

    ex_mem_to_reg_d = ex_mem_to_reg_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_alu_result_d = ex_alu_result_q;
    ex_write_data_d = ex_write_data_q;
    ex_dest_d       = ex_dest_q;

    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_read_data_d  = wb_read_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_dest_d       = wb_dest_q;

    if (!stall) begin
      ex_mem_to_reg_d = memToRegInput;
      ex_reg_write_d  = regWriteInput;
      ex_mem_write_d  = memWriteInput;
      ex_mem_read_d   = memReadInput;
      ex_alu_result_d = aluResultInput;
      ex_write_data_d = memWriteDataInput;
      ex_dest_d       = regWriteRegisterInput;

      wb_mem_to_reg_d = ex_mem_to_reg_q;
      wb_reg_write_d  = ex_reg_write_q;
      wb_alu_result_d = ex_alu_result_q;
      wb_dest_d       = ex_dest_q;
    end else begin
      // Bubble into write-back: nothing is written while the stage is held
      wb_mem_to_reg_d = 1'b0;
      wb_reg_write_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d    = capture_state;
        err_code_d = capture_code;
      end
      WAIT: begin
        if (mem.memAckInput) begin
          wait_count_d = 16'd0;
          if (ex_is_load) begin
            wb_read_data_d = mem.memReadDataInput;
          end
          state_d    = capture_state;
          err_code_d = capture_code;
        end else begin
          wait_count_d = wait_count_q + 16'd1;
          if (wait_count_q == WAIT_LAST) begin
            state_d    = ERROR;
            err_code_d = CODE_TIMEOUT;
          end
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state in one register bank; an asynchronous reset abandons any
  // pending access because the request is decoded from the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      err_code_q      <= 2'b00;
      wait_count_q    <= 16'd0;
      ex_mem_to_reg_q <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_alu_result_q <= 32'd0;
      ex_write_data_q <= 32'd0;
      ex_dest_q       <= 5'd0;
      wb_mem_to_reg_q <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_read_data_q  <= 32'd0;
      wb_alu_result_q <= 32'd0;
      wb_dest_q       <= 5'd0;
    end else begin
      state_q         <= state_d;
      err_code_q      <= err_code_d;
      wait_count_q    <= wait_count_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_alu_result_q <= ex_alu_result_d;
      ex_write_data_q <= ex_write_data_d;
      ex_dest_q       <= ex_dest_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_dest_q       <= wb_dest_d;
    end
  end

  // Bus is quiet outside WAIT; inside WAIT it comes straight from EX/MEM,
  // which is frozen by the stall, so it cannot change mid-access.
  always_comb begin
    mem.memReqOutput       = in_wait;
    mem.memWeOutput        = in_wait && ex_mem_write_q;
    mem.memAddressOutput   = in_wait ? ex_alu_result_q : 32'd0;
    mem.memWriteDataOutput = in_wait ? ex_write_data_q : 32'd0;

    // Writes to $zero are never forwarded
    aluResultMemOutput        = ex_alu_result_q;
    regWriteMemOutput         = ex_reg_write_q && (ex_dest_q != 5'd0);
    regWriteRegisterMemOutput = ex_dest_q;

    memToRegOutput         = wb_mem_to_reg_q;
    regWriteOutput         = wb_reg_write_q;
    readDataOutput         = wb_read_data_q;
    aluResultOutput        = wb_alu_result_q;
    regWriteRegisterOutput = wb_dest_q;

    stallOutput     = stall;
    errorOutput     = (state_q == ERROR);
    errorCodeOutput = err_code_q;
  end

endmodule

// File: tb/tb_memory_access.sv
// ----------------------------------------------------------------------------
// tb_memory_access
// Directed bench for the MEM stage: ALU pass-through, zero-wait load, store
// with wait states, back-to-back loads, misaligned and timeout faults, and an
// asynchronous reset in the middle of an access. The DUT runs with a short
// timeout so the timeout fault is reached in a few cycles.
// ----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;

  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic        mem_write_in;
  logic        mem_read_in;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic [4:0]  dest_in;

  logic [31:0] alu_result_mem;
  logic        reg_write_mem;
  logic [4:0]  dest_mem;
  logic        mem_to_reg_wb;
  logic        reg_write_wb;
  logic [31:0] read_data_wb;
  logic [31:0] alu_result_wb;
  logic [4:0]  dest_wb;
  logic        stall;
  logic        error;
  logic [1:0]  error_code;

  int assertion_count = 0;
  int failure_count   = 0;

  memory_access_if mem_bus ();

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .memToRegInput             (mem_to_reg_in),
    .regWriteInput             (reg_write_in),
    .memWriteInput             (mem_write_in),
    .memReadInput              (mem_read_in),
    .aluResultInput            (alu_result_in),
    .memWriteDataInput         (write_data_in),
    .regWriteRegisterInput     (dest_in),
    .mem                       (mem_bus.master),
    .aluResultMemOutput        (alu_result_mem),
    .regWriteMemOutput         (reg_write_mem),
    .regWriteRegisterMemOutput (dest_mem),
    .memToRegOutput            (mem_to_reg_wb),
    .regWriteOutput            (reg_write_wb),
    .readDataOutput            (read_data_wb),
    .aluResultOutput           (alu_result_wb),
    .regWriteRegisterOutput    (dest_wb),
    .stallOutput               (stall),
    .errorOutput               (error),
    .errorCodeOutput           (error_code)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertion_count++;
    if (observed !== expected) begin
      failure_count++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one EX result onto the stage inputs
  task automatic applyStimulus(input logic mem_to_reg, input logic reg_write,
                               input logic mem_write, input logic mem_read,
                               input logic [31:0] alu, input logic [31:0] wdata,
                               input logic [4:0] dest);
    mem_to_reg_in = mem_to_reg;
    reg_write_in  = reg_write;
    mem_write_in  = mem_write;
    mem_read_in   = mem_read;
    alu_result_in = alu;
    write_data_in = wdata;
    dest_in       = dest;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic setMem(input logic ack, input logic [31:0] data);
    mem_bus.memAckInput      = ack;
    mem_bus.memReadDataInput = data;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Global time bound so the bench can never hang
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyNop();
    setMem(1'b0, 32'd0);
    #3;
    checkOutput("reset_req",      mem_bus.memReqOutput, 32'd0);
    checkOutput("reset_stall",    stall,                32'd0);
    checkOutput("reset_error",    error,                32'd0);
    checkOutput("reset_wb_alu",   alu_result_wb,        32'd0);
    checkOutput("reset_wb_write", reg_write_wb,         32'd0);
    @(posedge clk);
    tick();
    reset = 1'b1;

    // ALU op: one cycle to EX/MEM, another to MEM/WB
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'd0, 5'd5);
    #1 checkOutput("alu_stall_pre", stall, 32'd0);
    tick();
    applyNop();
    #1;
    checkOutput("alu_fwd_result", alu_result_mem, 32'h2A);
    checkOutput("alu_fwd_write",  reg_write_mem,  32'd1);
    checkOutput("alu_fwd_dest",   dest_mem,       32'd5);
    checkOutput("alu_wb_early",   alu_result_wb,  32'd0);
    checkOutput("alu_stall_mem",  stall,          32'd0);
    tick();
    #1;
    checkOutput("alu_wb_result", alu_result_wb, 32'h2A);
    checkOutput("alu_wb_write",  reg_write_wb,  32'd1);
    checkOutput("alu_wb_dest",   dest_wb,       32'd5);
    checkOutput("alu_stall_wb",  stall,         32'd0);

    // Write to $zero must not be forwarded
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'd0, 5'd0);
    tick();
    applyNop();
    #1;
    checkOutput("zero_fwd_write",  reg_write_mem,  32'd0);
    checkOutput("zero_fwd_result", alu_result_mem, 32'h99);

    // Load acked in its first WAIT cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd7);
    tick();
    applyNop();
    setMem(1'b1, 32'hDEAD_BEEF);
    #1;
    checkOutput("ld0_req",   mem_bus.memReqOutput,     32'd1);
    checkOutput("ld0_we",    mem_bus.memWeOutput,      32'd0);
    checkOutput("ld0_addr",  mem_bus.memAddressOutput, 32'h100);
    checkOutput("ld0_stall", stall,                    32'd0);
    tick();
    setMem(1'b0, 32'd0);
    #1;
    checkOutput("ld0_req_done",   mem_bus.memReqOutput, 32'd0);
    checkOutput("ld0_rdata",      read_data_wb,         32'hDEAD_BEEF);
    checkOutput("ld0_mem_to_reg", mem_to_reg_wb,        32'd1);
    checkOutput("ld0_wb_write",   reg_write_wb,         32'd1);
    checkOutput("ld0_wb_dest",    dest_wb,              32'd7);

    // Store with three wait states, preceded by an ALU op so the bubble shows
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0066, 32'd0, 5'd6);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_1234, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'd0, 5'd9);
    #1;
    checkOutput("st_w1_req",      mem_bus.memReqOutput,       32'd1);
    checkOutput("st_w1_we",       mem_bus.memWeOutput,        32'd1);
    checkOutput("st_w1_addr",     mem_bus.memAddressOutput,   32'h200);
    checkOutput("st_w1_wdata",    mem_bus.memWriteDataOutput, 32'h1234);
    checkOutput("st_w1_stall",    stall,                      32'd1);
    checkOutput("st_w1_wb_write", reg_write_wb,               32'd1);
    for (int w = 2; w <= 3; w++) begin
      tick();
      #1;
      checkOutput($sformatf("st_w%0d_req", w),      mem_bus.memReqOutput,       32'd1);
      checkOutput($sformatf("st_w%0d_we", w),       mem_bus.memWeOutput,        32'd1);
      checkOutput($sformatf("st_w%0d_addr", w),     mem_bus.memAddressOutput,   32'h200);
      checkOutput($sformatf("st_w%0d_wdata", w),    mem_bus.memWriteDataOutput, 32'h1234);
      checkOutput($sformatf("st_w%0d_stall", w),    stall,                      32'd1);
      checkOutput($sformatf("st_w%0d_bubble", w),   reg_write_wb,               32'd0);
      checkOutput($sformatf("st_w%0d_m2r", w),      mem_to_reg_wb,              32'd0);
      checkOutput($sformatf("st_w%0d_wb_alu", w),   alu_result_wb,              32'h66);
      checkOutput($sformatf("st_w%0d_exmem", w),    alu_result_mem,             32'h200);
      checkOutput($sformatf("st_w%0d_rdata", w),    read_data_wb,               32'hDEAD_BEEF);
    end
    tick();
    setMem(1'b1, 32'hFFFF_FFFF);
    #1;
    checkOutput("st_w4_req",   mem_bus.memReqOutput,     32'd1);
    checkOutput("st_w4_we",    mem_bus.memWeOutput,      32'd1);
    checkOutput("st_w4_addr",  mem_bus.memAddressOutput, 32'h200);
    checkOutput("st_w4_stall", stall,                    32'd0);
    tick();
    setMem(1'b0, 32'd0);
    applyNop();
    #1;
    checkOutput("st_done_req",    mem_bus.memReqOutput, 32'd0);
    checkOutput("st_next_exmem",  alu_result_mem,       32'h55);
    checkOutput("st_next_dest",   dest_mem,             32'd9);
    checkOutput("st_rdata_kept",  read_data_wb,         32'hDEAD_BEEF);
    checkOutput("st_wb_alu",      alu_result_wb,        32'h200);
    checkOutput("st_wb_write",    reg_write_wb,         32'd0);

    // Back-to-back loads, each acked at once
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'd0, 5'd8);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0014, 32'd0, 5'd9);
    setMem(1'b1, 32'h1111_0010);
    #1;
    checkOutput("b2b_1_req",   mem_bus.memReqOutput,     32'd1);
    checkOutput("b2b_1_addr",  mem_bus.memAddressOutput, 32'h10);
    checkOutput("b2b_1_stall", stall,                    32'd0);
    tick();
    applyNop();
    setMem(1'b1, 32'h2222_0014);
    #1;
    checkOutput("b2b_2_req",   mem_bus.memReqOutput,     32'd1);
    checkOutput("b2b_2_addr",  mem_bus.memAddressOutput, 32'h14);
    checkOutput("b2b_2_stall", stall,                    32'd0);
    checkOutput("b2b_1_rdata", read_data_wb,             32'h1111_0010);
    checkOutput("b2b_1_dest",  dest_wb,                  32'd8);
    tick();
    setMem(1'b0, 32'd0);
    #1;
    checkOutput("b2b_done_req", mem_bus.memReqOutput, 32'd0);
    checkOutput("b2b_2_rdata",  read_data_wb,         32'h2222_0014);
    checkOutput("b2b_2_dest",   dest_wb,              32'd9);
    checkOutput("b2b_2_m2r",    mem_to_reg_wb,        32'd1);

    // Timeout: four WAIT cycles with no ack, then the fault
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'd0, 5'd10);
    tick();
    applyNop();
    for (int w = 1; w <= 4; w++) begin
      #1;
      checkOutput($sformatf("to_w%0d_req", w),   mem_bus.memReqOutput, 32'd1);
      checkOutput($sformatf("to_w%0d_error", w), error,                32'd0);
      tick();
    end
    #1;
    checkOutput("to_req",   mem_bus.memReqOutput, 32'd0);
    checkOutput("to_error", error,                32'd1);
    checkOutput("to_code",  error_code,           32'd2);
    checkOutput("to_stall", stall,                32'd1);
    setMem(1'b1, 32'h0BAD_0BAD);
    tick();
    #1;
    checkOutput("to_sticky_code",  error_code, 32'd2);
    checkOutput("to_sticky_stall", stall,      32'd1);
    checkOutput("to_sticky_req",   mem_bus.memReqOutput, 32'd0);
    setMem(1'b0, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("to_rst_error", error,      32'd0);
    checkOutput("to_rst_code",  error_code, 32'd0);
    checkOutput("to_rst_stall", stall,      32'd0);
    tick();
    reset = 1'b1;

    // Misaligned load faults without ever requesting
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'd0, 5'd11);
    tick();
    applyNop();
    #1;
    checkOutput("mis_req",   mem_bus.memReqOutput, 32'd0);
    checkOutput("mis_error", error,                32'd1);
    checkOutput("mis_code",  error_code,           32'd1);
    checkOutput("mis_stall", stall,                32'd1);
    tick();
    tick();
    #1;
    checkOutput("mis_hold_stall", stall,                32'd1);
    checkOutput("mis_hold_req",   mem_bus.memReqOutput, 32'd0);
    checkOutput("mis_hold_code",  error_code,           32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Asynchronous reset in the middle of a WAIT
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'd0, 5'd4);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'd0, 5'd3);
    tick();
    applyNop();
    #1;
    checkOutput("mrst_pre_req",    mem_bus.memReqOutput, 32'd1);
    checkOutput("mrst_pre_wb_alu", alu_result_wb,        32'h77);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mrst_req",       mem_bus.memReqOutput, 32'd0);
    checkOutput("mrst_stall",     stall,                32'd0);
    checkOutput("mrst_wb_write",  reg_write_wb,         32'd0);
    checkOutput("mrst_wb_m2r",    mem_to_reg_wb,        32'd0);
    checkOutput("mrst_wb_alu",    alu_result_wb,        32'd0);
    checkOutput("mrst_wb_dest",   dest_wb,              32'd0);
    checkOutput("mrst_wb_rdata",  read_data_wb,         32'd0);
    checkOutput("mrst_exmem_alu", alu_result_mem,       32'd0);
    tick();
    reset = 1'b1;
    setMem(1'b1, 32'h0000_ABCD);
    #1;
    checkOutput("mrst_idle_req",   mem_bus.memReqOutput, 32'd0);
    checkOutput("mrst_idle_stall", stall,                32'd0);
    tick();
    #1;
    checkOutput("mrst_no_reissue", mem_bus.memReqOutput, 32'd0);
    checkOutput("mrst_ack_ignored", read_data_wb,        32'd0);
    checkOutput("mrst_no_error",   error,                32'd0);
    setMem(1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
    $finish;
  end

endmodule
